// File: rtl/sha_engine_dispatcher_if.sv
// rtl/sha_engine_dispatcher_if.sv - packet, engine and digest stream bundle for sha_engine_dispatcher
// slave = dispatcher side, master = the surrounding crossbar/engine side.
interface sha_engine_dispatcher_if #(
  parameter int NUM_ENGINES  = 4,
  parameter int DATA_WIDTH   = 512,
  parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int ENG_ID_WIDTH = 3
);
  localparam int DIG_W = 512;

  logic [DATA_WIDTH-1:0]             s_axis_tdata;
  logic [KEEP_WIDTH-1:0]             s_axis_tkeep;
  logic                              s_axis_tvalid;
  logic                              s_axis_tready;
  logic                              s_axis_tlast;

  logic [NUM_ENGINES*DATA_WIDTH-1:0] m_eng_tdata;
  logic [NUM_ENGINES*KEEP_WIDTH-1:0] m_eng_tkeep;
  logic [NUM_ENGINES-1:0]            m_eng_tvalid;
  logic [NUM_ENGINES-1:0]            m_eng_tready;
  logic [NUM_ENGINES-1:0]            m_eng_tlast;

  logic [NUM_ENGINES*DIG_W-1:0]      s_dig_tdata;
  logic [NUM_ENGINES-1:0]            s_dig_tvalid;
  logic [NUM_ENGINES-1:0]            s_dig_tready;

  logic [DIG_W-1:0]                  m_dig_tdata;
  logic                              m_dig_tvalid;
  logic                              m_dig_tready;
  logic [ENG_ID_WIDTH-1:0]           m_dig_eng_id;

  logic                              busy;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_eng_tdata, m_eng_tkeep, m_eng_tvalid, m_eng_tlast,
    input  m_eng_tready,
    input  s_dig_tdata, s_dig_tvalid,
    output s_dig_tready,
    output m_dig_tdata, m_dig_tvalid, m_dig_eng_id,
    input  m_dig_tready,
    output busy
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_eng_tdata, m_eng_tkeep, m_eng_tvalid, m_eng_tlast,
    output m_eng_tready,
    output s_dig_tdata, s_dig_tvalid,
    input  s_dig_tready,
    input  m_dig_tdata, m_dig_tvalid, m_dig_eng_id,
    output m_dig_tready,
    input  busy
  );
endinterface

// File: rtl/sha_engine_dispatcher.sv
// rtl/sha_engine_dispatcher.sv - round-robin packet dispatch to SHA engines with in-order digest return
// Optional per-engine dispatch counters on stat_pkt_cnt when SHA_DISPATCH_STATS_EN is defined.
module sha_engine_dispatcher #(
  parameter int NUM_ENGINES     = 4,
  parameter int DATA_WIDTH      = 512,
  parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ORDER_DEPTH     = 16,
  parameter int ENG_ID_WIDTH    = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sha_engine_dispatcher_if.slave   bus
`ifdef SHA_DISPATCH_STATS_EN
  ,
  output logic [NUM_ENGINES*32-1:0] stat_pkt_cnt
`endif
);

  localparam int DIG_W    = 512;
  localparam int CREDIT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W    = $clog2(ORDER_DEPTH);
  localparam logic [CREDIT_W-1:0]     CREDIT_MAX = CREDIT_W'(MAX_OUTSTANDING);
  localparam logic [ENG_ID_WIDTH-1:0] RR_INIT    = ENG_ID_WIDTH'(NUM_ENGINES - 1);

  typedef enum logic {IDLE, FWD} state_t;

  state_t                  state, state_nxt;
  logic [ENG_ID_WIDTH-1:0] sel, rr, pick, head;
  logic                    pick_vld;
  logic [NUM_ENGINES-1:0]  eligible;
  logic [NUM_ENGINES-1:0]  credit_inc, credit_dec;
  logic [CREDIT_W-1:0]     credit [NUM_ENGINES];

  logic [ENG_ID_WIDTH-1:0] order_mem [ORDER_DEPTH];
  logic [PTR_W:0]          wr_ptr, rd_ptr;
  logic                    fifo_empty, fifo_full;
  logic                    push, pop, fwd_last_hs;
  logic                    sel_ready, head_dig_valid;
  logic [DIG_W-1:0]        head_dig_data;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head       = order_mem[rd_ptr[PTR_W-1:0]];

  always_comb begin
    eligible = '0;
    for (int e = 0; e < NUM_ENGINES; e++) begin
      eligible[e] = (credit[e] < CREDIT_MAX);
    end
  end

  // First eligible engine strictly after rr, wrapping around.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 1; i <= NUM_ENGINES; i++) begin
      for (int e = 0; e < NUM_ENGINES; e++) begin
        if (!pick_vld && eligible[e] && (e == (int'(rr) + i) % NUM_ENGINES)) begin
          pick     = ENG_ID_WIDTH'(e);
          pick_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_ready      = 1'b0;
    head_dig_valid = 1'b0;
    head_dig_data  = '0;
    for (int e = 0; e < NUM_ENGINES; e++) begin
      if (sel == ENG_ID_WIDTH'(e)) begin
        sel_ready = bus.m_eng_tready[e];
      end
      if (head == ENG_ID_WIDTH'(e)) begin
        head_dig_valid = bus.s_dig_tvalid[e];
        head_dig_data  = bus.s_dig_tdata[e*DIG_W +: DIG_W];
      end
    end
  end

  assign push        = (state == IDLE) && !fifo_full && pick_vld;
  assign fwd_last_hs = (state == FWD) && bus.s_axis_tvalid && sel_ready && bus.s_axis_tlast;
  assign pop         = !fifo_empty && head_dig_valid && bus.m_dig_tready;

  always_comb begin
    credit_inc = '0;
    credit_dec = '0;
    for (int e = 0; e < NUM_ENGINES; e++) begin
      credit_inc[e] = push && (pick == ENG_ID_WIDTH'(e));
      credit_dec[e] = pop && (head == ENG_ID_WIDTH'(e));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (push) state_nxt = FWD;
      FWD:     if (fwd_last_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel    <= '0;
      rr     <= RR_INIT;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        sel    <= pick;
        rr     <= pick;
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
    end
  end

  // Tag storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      order_mem[wr_ptr[PTR_W-1:0]] <= pick;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < NUM_ENGINES; e++) begin
        credit[e] <= '0;
      end
    end else begin
      for (int e = 0; e < NUM_ENGINES; e++) begin
        if (credit_inc[e] && !credit_dec[e]) begin
          credit[e] <= credit[e] + CREDIT_W'(1);
        end else if (!credit_inc[e] && credit_dec[e]) begin
          credit[e] <= credit[e] - CREDIT_W'(1);
        end
      end
    end
  end

  assign bus.m_eng_tdata = {NUM_ENGINES{bus.s_axis_tdata}};
  assign bus.m_eng_tkeep = {NUM_ENGINES{bus.s_axis_tkeep}};
  assign bus.m_eng_tlast = {NUM_ENGINES{bus.s_axis_tlast}};

  always_comb begin
    bus.m_eng_tvalid = '0;
    for (int e = 0; e < NUM_ENGINES; e++) begin
      if ((state == FWD) && (sel == ENG_ID_WIDTH'(e))) begin
        bus.m_eng_tvalid[e] = bus.s_axis_tvalid;
      end
    end
  end

  assign bus.s_axis_tready = (state == FWD) && sel_ready;

  // Only the oldest outstanding engine is readied; the rest hold their digests.
  always_comb begin
    bus.s_dig_tready = '0;
    for (int e = 0; e < NUM_ENGINES; e++) begin
      bus.s_dig_tready[e] = bus.m_dig_tready && !fifo_empty && (head == ENG_ID_WIDTH'(e));
    end
  end

  assign bus.m_dig_tvalid = !fifo_empty && head_dig_valid;
  assign bus.m_dig_tdata  = head_dig_data;
  assign bus.m_dig_eng_id = fifo_empty ? '0 : head;
  assign bus.busy         = (state == FWD) || !fifo_empty;

`ifdef SHA_DISPATCH_STATS_EN
  logic [31:0] stat_cnt [NUM_ENGINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < NUM_ENGINES; e++) begin
        stat_cnt[e] <= '0;
      end
    end else begin
      for (int e = 0; e < NUM_ENGINES; e++) begin
        if (credit_inc[e]) begin
          stat_cnt[e] <= stat_cnt[e] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    stat_pkt_cnt = '0;
    for (int e = 0; e < NUM_ENGINES; e++) begin
      stat_pkt_cnt[e*32 +: 32] = stat_cnt[e];
    end
  end
`else
  // Dispatch counters are not built in this configuration.
`endif

endmodule
